// File: rtl/tdm_pkg.sv
// Shared TDM framing definitions for the 4-channel mux/demux pair.
// Latency: none (constants, types and helpers only).
// Backpressure: none; TDM links are free-running with no flow control.
package tdm_pkg;

  // Channels per frame and default channel word width
  localparam int TDM_NCH     = 4;
  localparam int TDM_W_DEF   = 8;
  localparam int TDM_CH_BITS = 2;

  // Two-state frame FSM encoding, shared with the transmitter
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RECV = 1'b1;

  typedef logic [TDM_CH_BITS-1:0] chan_t;

  // True when c is the final channel slot of a frame
  function automatic logic is_last_chan(input chan_t c);
    return c == chan_t'(TDM_NCH - 1);
  endfunction

  // Next channel slot, wrapping after the final channel
  function automatic chan_t next_chan(input chan_t c);
    return is_last_chan(c) ? chan_t'(0) : chan_t'(c + chan_t'(1));
  endfunction

endpackage

// File: rtl/tdm_slot_counter.sv
// Bit/channel position tracker: mod-W bit count, mod-4 channel count, last-bit flag.
// Latency: counters update on the clock edge; last is combinational from the counters.
// Backpressure: none; advances whenever adv is high.
module tdm_slot_counter
  import tdm_pkg::*;
#(
  parameter int W = TDM_W_DEF
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  load,   // start of frame: first bit is being captured this edge
  input  logic  adv,    // one more bit captured this edge (ignored when load)
  input  logic  clr,    // frame complete: return to slot 0
  output chan_t chan,
  output logic  last    // the bit being captured now is channel 3 bit 0
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] BIT_MAX = CW'(W - 1);

  logic [CW-1:0] bit_cnt;

  // Position registers; load wins so a resync restarts cleanly mid-frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt <= '0;
      chan    <= '0;
    end else if (load) begin
      // The start edge already captured channel 0 bit W-1
      bit_cnt <= CW'(1);
      chan    <= '0;
    end else if (clr) begin
      bit_cnt <= '0;
      chan    <= '0;
    end else if (adv) begin
      if (bit_cnt == BIT_MAX) begin
        bit_cnt <= '0;
        chan    <= next_chan(chan);
      end else begin
        bit_cnt <= bit_cnt + CW'(1);
      end
    end
  end

  // Last bit of the frame is the final bit slot of the final channel
  always_comb begin
    last = is_last_chan(chan) && (bit_cnt == BIT_MAX);
  end

endmodule

// File: rtl/tdm_demux4.sv
// Serial TDM receiver: splits a 4*W-bit frame into four W-bit channel words.
// Latency: Y0..Y3 and valid appear one edge after the frame's last bit.
// Backpressure: none; a start pulse mid-frame aborts it with a one-cycle err.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int W = TDM_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         D,
  input  logic         start,
  output logic [W-1:0] Y0,
  output logic [W-1:0] Y1,
  output logic [W-1:0] Y2,
  output logic [W-1:0] Y3,
  output logic         valid,
  output logic         err,
  output logic         busy,
  output logic [1:0]   chan
);

  logic [0:0]                   state;
  logic [TDM_NCH-1:0][W-1:0]    stage;
  chan_t                        slot_chan;
  logic                         slot_last;
  logic                         recv_bit;
  logic                         frame_done;
  logic                         resync;

  // Control decode: a start always wins over an in-progress bit
  always_comb begin
    recv_bit   = (state == ST_RECV) && !start;
    frame_done = recv_bit && slot_last;
    resync     = (state == ST_RECV) && start;
  end

  tdm_slot_counter #(
    .W (W)
  ) u_slot (
    .clk   (clk),
    .reset (reset),
    .load  (start),
    .adv   (recv_bit),
    .clr   (frame_done),
    .chan  (slot_chan),
    .last  (slot_last)
  );

  // Frame FSM: any start enters RECV, the final bit returns to IDLE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else if (start) begin
      state <= ST_RECV;
    end else if (frame_done) begin
      state <= ST_IDLE;
    end
  end

  // Staging shift registers, MSB arrives first so shift left into bit 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage <= '0;
    end else if (start) begin
      stage[0] <= {{(W-1){1'b0}}, D};
    end else if (recv_bit) begin
      stage[slot_chan] <= {stage[slot_chan][W-2:0], D};
    end
  end

  // Output words load together only on a complete frame; flags are single pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Y0    <= '0;
      Y1    <= '0;
      Y2    <= '0;
      Y3    <= '0;
      valid <= 1'b0;
      err   <= 1'b0;
    end else begin
      valid <= frame_done;
      err   <= resync;
      if (frame_done) begin
        Y0 <= stage[0];
        Y1 <= stage[1];
        Y2 <= stage[2];
        // Channel 3 bit 0 is on D right now, not yet in staging
        Y3 <= {stage[3][W-2:0], D};
      end
    end
  end

  // Status outputs follow the registered state and slot position
  always_comb begin
    busy = (state == ST_RECV);
    chan = slot_chan;
  end

  // A frame cannot both complete and abort on the same edge
  a_valid_err_excl: assert property (@(posedge clk) disable iff (reset) !(valid && err));

endmodule

// File: tb/tb_tdm_demux4.sv
module tb_tdm_demux4;

  logic       clk;
  logic       rst;
  logic       D, start;
  logic [7:0] Y0, Y1, Y2, Y3;
  logic       valid, err, busy;
  logic [1:0] chan;

  logic       d4, s4;
  logic [3:0] Z0, Z1, Z2, Z3;
  logic       valid4, err4, busy4;
  logic [1:0] chan4;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int errs  = 0;
  int vcyc[$];

  // Behavioural reference: a frame is just a list of received bits
  logic        m_busy;
  int          m_nbits;
  logic [31:0] m_frame;
  logic [7:0]  m_y[4];
  logic        m_valid, m_err;

  typedef struct {
    logic [31:0] frame;
    int          abort_bit;
    logic [31:0] exp_y;
    int          exp_err;
  } vec_t;

  vec_t tbl[5];

  tdm_demux4 #(.W(8)) dut8 (
    .clk(clk), .reset(rst), .D(D), .start(start),
    .Y0(Y0), .Y1(Y1), .Y2(Y2), .Y3(Y3),
    .valid(valid), .err(err), .busy(busy), .chan(chan)
  );

  tdm_demux4 #(.W(4)) dut4 (
    .clk(clk), .reset(rst), .D(d4), .start(s4),
    .Y0(Z0), .Y1(Z1), .Y2(Z2), .Y3(Z3),
    .valid(valid4), .err(err4), .busy(busy4), .chan(chan4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_nbits = 0; m_frame = '0;
    m_valid = 0; m_err = 0;
    for (int i = 0; i < 4; i++) m_y[i] = '0;
  endtask

  task automatic model_edge(input logic d, input logic s);
    m_valid = 0;
    m_err   = 0;
    if (s) begin
      if (m_busy) m_err = 1;
      m_busy  = 1;
      m_frame = {31'd0, d};
      m_nbits = 1;
    end else if (m_busy) begin
      m_frame = {m_frame[30:0], d};
      m_nbits++;
      if (m_nbits == 32) begin
        for (int i = 0; i < 4; i++) m_y[i] = m_frame[(3-i)*8 +: 8];
        m_valid = 1;
        m_busy  = 0;
        m_nbits = 0;
      end
    end
  endtask

  // Called at a falling edge: drive, clock, then compare at the next falling edge
  task automatic step(input logic d, input logic s);
    D = d;
    start = s;
    @(posedge clk);
    model_edge(d, s);
    @(negedge clk);
    cyc++;
    chk("y0", {24'd0, Y0}, {24'd0, m_y[0]});
    chk("y1", {24'd0, Y1}, {24'd0, m_y[1]});
    chk("y2", {24'd0, Y2}, {24'd0, m_y[2]});
    chk("y3", {24'd0, Y3}, {24'd0, m_y[3]});
    chk("valid", {31'd0, valid}, {31'd0, m_valid});
    chk("err", {31'd0, err}, {31'd0, m_err});
    chk("busy", {31'd0, busy}, {31'd0, m_busy});
    chk("chan", {30'd0, chan}, m_busy ? 32'(m_nbits / 8) : 32'd0);
    if (valid) vcyc.push_back(cyc);
    if (err) errs++;
  endtask

  task automatic send_frame(input logic [31:0] f);
    for (int i = 0; i < 32; i++) step(f[31-i], i == 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_y"}, {Y0, Y1, Y2, Y3}, 32'd0);
    chk({tag, "_flags"}, {28'd0, valid, err, busy, 1'b0}, 32'd0);
    chk({tag, "_chan"}, {30'd0, chan}, 32'd0);
  endtask

  initial begin
    logic [15:0] nib;
    int          v0;
    int          e0;

    tbl[0] = '{32'hA53CFF01, -1, 32'hA53CFF01, 0};
    tbl[1] = '{32'h00112233, -1, 32'h00112233, 0};
    tbl[2] = '{32'h12345678, 10, 32'h12345678, 1};
    tbl[3] = '{32'hFFFFFFFF, -1, 32'hFFFFFFFF, 0};
    tbl[4] = '{32'h80000001,  3, 32'h80000001, 1};

    rst = 1'b1; D = 1'b0; start = 1'b0; d4 = 1'b0; s4 = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    chk("reset_dut4", {Z0, Z1, Z2, Z3, 12'd0, valid4, err4, busy4, 1'b0}, 32'd0);
    rst = 1'b0;

    // Start is required: data alone must not begin a frame
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0);

    // Table of frames, some preceded by an aborted partial frame
    for (int k = 0; k < 5; k++) begin
      vcyc.delete();
      e0 = errs;
      if (tbl[k].abort_bit >= 0)
        for (int i = 0; i < tbl[k].abort_bit; i++) step(1'($urandom_range(0, 1)), i == 0);
      send_frame(tbl[k].frame);
      step(1'b0, 1'b0);
      chk("tbl_y", {Y0, Y1, Y2, Y3}, tbl[k].exp_y);
      chk("tbl_valid_cnt", 32'(vcyc.size()), 32'd1);
      chk("tbl_err_cnt", 32'(errs - e0), 32'(tbl[k].exp_err));
    end

    // Idle with toggling data holds everything
    for (int i = 0; i < 50; i++) step(1'(i % 2), 1'b0);
    chk("idle_y", {Y0, Y1, Y2, Y3}, 32'h80000001);

    // Back-to-back frames with no gap
    vcyc.delete();
    send_frame(32'hA53CFF01);
    send_frame(32'h00112233);
    step(1'b0, 1'b0);
    chk("b2b_cnt", 32'(vcyc.size()), 32'd2);
    if (vcyc.size() == 2) chk("b2b_gap", 32'(vcyc[1] - vcyc[0]), 32'd32);
    chk("b2b_y", {Y0, Y1, Y2, Y3}, 32'h00112233);

    // Resync at bit 10 after a good frame
    e0 = errs;
    send_frame(32'hA53CFF01);
    for (int i = 0; i < 10; i++) step(1'($urandom_range(0, 1)), i == 0);
    chk("resync_y_hold", {Y0, Y1, Y2, Y3}, 32'hA53CFF01);
    vcyc.delete();
    send_frame(32'h12345678);
    step(1'b0, 1'b0);
    chk("resync_err_cnt", 32'(errs - e0), 32'd1);
    chk("resync_valid_cnt", 32'(vcyc.size()), 32'd1);
    chk("resync_y", {Y0, Y1, Y2, Y3}, 32'h12345678);

    // Asynchronous reset in the middle of a frame
    for (int i = 0; i < 15; i++) step(1'b1, i == 0);
    D = 1'b0; start = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_zero_outputs("async_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    v0 = vcyc.size();
    e0 = errs;
    for (int i = 0; i < 40; i++) step(1'($urandom_range(0, 1)), 1'b0);
    chk("post_rst_no_valid", 32'(vcyc.size() - v0), 32'd0);
    chk("post_rst_no_err", 32'(errs - e0), 32'd0);

    // Random data with occasional starts, checked against the reference every cycle
    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 1)), $urandom_range(0, 39) == 0);

    // Narrow instance: W=4, nibbles 9 6 F 0
    D = 1'b0; start = 1'b0;
    nib = 16'h96F0;
    for (int i = 0; i < 16; i++) begin
      d4 = nib[15-i];
      s4 = (i == 0);
      @(posedge clk);
      @(negedge clk);
      if (i < 15) chk("w4_no_valid_early", {31'd0, valid4}, 32'd0);
    end
    chk("w4_valid", {31'd0, valid4}, 32'd1);
    chk("w4_y", {16'd0, Z0, Z1, Z2, Z3}, 32'h000096F0);
    chk("w4_busy_done", {31'd0, busy4}, 32'd0);
    d4 = 1'b0; s4 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("w4_valid_one_cycle", {31'd0, valid4}, 32'd0);
    chk("w4_y_hold", {16'd0, Z0, Z1, Z2, Z3}, 32'h000096F0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
